// File: rtl/frame_pkg.sv
// frame_pkg: shared encodings for the frame scheduler and its helpers.
package frame_pkg;

    // Scheduler states: collect a frame, wait for the transmitter, stream it out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        SEND  = 2'd3
    } state_e;

    // Which requester owns the frame being filled or sent.
    typedef enum logic {
        OWNER_TRACE  = 1'b0,
        OWNER_STATUS = 1'b1
    } owner_e;

    // Filler written into unused slots when a requester goes quiet mid-frame.
    localparam logic [15:0] PAD_WORD = 16'h0000;

endpackage

// File: rtl/frame_scheduler_sync_edge.sv
// sync_edge: multi-flop synchroniser for a dClk-domain level, followed by a
// rising-edge detector in the clk domain.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_evt
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the raw input through the chain and remember the last synchronised level.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = async_in;
        prev_d    = sync_q[STAGES-1];
        rise_evt  = sync_q[STAGES-1] & ~prev_q;
    end

    // Synchroniser and edge-history flops, cleared together on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: arbitrates a trace and a status requester into fixed-size
// frames and hands each completed frame to a dClk-domain SPI transmitter.
module frame_scheduler
    import frame_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 8,
    parameter int PAD_TIMEOUT     = 255,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] trc_word,
    input  logic        trc_valid,
    output logic        trc_ready,
    input  logic [15:0] sts_word,
    input  logic        sts_valid,
    output logic        sts_ready,
    input  logic        tx_free,
    input  logic        rxFrameReset,
    output logic        transmitIn,
    output logic [15:0] tx_word,
    output logic [15:0] frames_sent
);

    localparam int IDX_W = $clog2(WORDS_PER_FRAME + 1);
    localparam int PTR_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int TO_W  = (PAD_TIMEOUT > 1) ? $clog2(PAD_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(WORDS_PER_FRAME);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PAD_TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic              padding_q, padding_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              transmit_q, transmit_d;
    logic [15:0]       tx_word_q, tx_word_d;
    logic [15:0]       buf_q [WORDS_PER_FRAME];

    logic              free_evt, abort_evt;
    logic              fill_open, in_hs;
    logic [15:0]       in_word;
    logic              wr_en;
    logic [15:0]       wr_data;

    sync_edge #(.STAGES(SYNC_STAGES)) u_free_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (tx_free),
        .rise_evt (free_evt)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_abort_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rxFrameReset),
        .rise_evt (abort_evt)
    );

    // Only the frame owner sees ready, and only while slots remain and no padding runs.
    always_comb begin
        fill_open = !rst && (state_q == FILL) && !padding_q && (wr_idx_q < FULL_IDX);
        trc_ready = fill_open && (owner_q == OWNER_TRACE) && trc_valid;
        sts_ready = fill_open && (owner_q == OWNER_STATUS) && sts_valid;
        in_hs     = trc_ready || sts_ready;
        in_word   = (owner_q == OWNER_STATUS) ? sts_word : trc_word;
    end

    // Next-state logic: arbitration, filling/padding, transmit handshakes and abort.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        timeout_d     = timeout_q;
        padding_d     = padding_q;
        frames_sent_d = frames_sent_q;
        wr_en         = 1'b0;
        wr_data       = PAD_WORD;
        case (state_q)
            IDLE: begin
                if (trc_valid || sts_valid) begin
                    owner_d   = (sts_valid && ((last_owner_q == OWNER_TRACE) || !trc_valid))
                                ? OWNER_STATUS : OWNER_TRACE;
                    state_d   = FILL;
                    wr_idx_d  = '0;
                    timeout_d = '0;
                    padding_d = 1'b0;
                end
            end
            FILL: begin
                if (wr_idx_q == FULL_IDX) begin
                    state_d   = ARMED;
                    rd_idx_d  = '0;
                    padding_d = 1'b0;
                end else if (padding_q) begin
                    wr_en    = 1'b1;
                    wr_data  = PAD_WORD;
                    wr_idx_d = wr_idx_q + 1'b1;
                end else if (in_hs) begin
                    wr_en     = 1'b1;
                    wr_data   = in_word;
                    wr_idx_d  = wr_idx_q + 1'b1;
                    timeout_d = '0;
                end else if (timeout_q == TO_LAST) begin
                    padding_d = 1'b1;
                    timeout_d = '0;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            ARMED: begin
                if (abort_evt) begin
                    rd_idx_d = '0;
                end else if (free_evt) begin
                    state_d  = SEND;
                    rd_idx_d = IDX_W'(1);
                end
            end
            SEND: begin
                if (abort_evt) begin
                    state_d  = ARMED;
                    rd_idx_d = '0;
                end else if (free_evt) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d       = IDLE;
                        rd_idx_d      = '0;
                        frames_sent_d = frames_sent_q + 16'd1;
                        last_owner_d  = owner_q;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        transmit_d = (state_d == ARMED) || (state_d == SEND);
        tx_word_d  = transmit_d ? buf_q[rd_idx_d[PTR_W-1:0]] : 16'h0000;
    end

    // State, counters and registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_TRACE;
            last_owner_q  <= OWNER_TRACE;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            timeout_q     <= '0;
            padding_q     <= 1'b0;
            frames_sent_q <= 16'd0;
            transmit_q    <= 1'b0;
            tx_word_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            timeout_q     <= timeout_d;
            padding_q     <= padding_d;
            frames_sent_q <= frames_sent_d;
            transmit_q    <= transmit_d;
            tx_word_q     <= tx_word_d;
        end
    end

    // Frame storage; contents are only meaningful once the FSM has filled them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_idx_q[PTR_W-1:0]] <= wr_data;
        end
    end

    assign transmitIn  = transmit_q;
    assign tx_word     = tx_word_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: randomized scoreboard bench for frame_scheduler.
module tb_frame_scheduler;

    localparam int WPF    = 8;
    localparam int PAD_TO = 20;

    localparam int PLAN_NORMAL = 0;
    localparam int PLAN_ABORT  = 1;
    localparam int PLAN_BOTH   = 2;
    localparam int PLAN_RESET  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] trc_word, sts_word;
    logic        trc_valid, sts_valid, trc_ready, sts_ready;
    logic        tx_free, rxFrameReset, transmitIn;
    logic [15:0] tx_word, frames_sent;

    always #5 clk = ~clk;

    frame_scheduler #(
        .WORDS_PER_FRAME (WPF),
        .PAD_TIMEOUT     (PAD_TO),
        .SYNC_STAGES     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trc_word     (trc_word),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .sts_word     (sts_word),
        .sts_valid    (sts_valid),
        .sts_ready    (sts_ready),
        .tx_free      (tx_free),
        .rxFrameReset (rxFrameReset),
        .transmitIn   (transmitIn),
        .tx_word      (tx_word),
        .frames_sent  (frames_sent)
    );

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  gap;
    } src_t;

    typedef struct packed {
        logic [WPF*16-1:0] words;
        logic [1:0]        plan;
        logic [3:0]        at;
    } exp_t;

    src_t trc_src[$];
    src_t sts_src[$];
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int planned = 0;
    int frames_done = 0;
    int exp_frames = 0;
    int both_ready_cycles = 0;
    bit halted = 1'b0;
    bit last_owner_sts = 1'b0;

    // One comparison: counts it, and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue one frame's words on a requester and push the frame the sink must see.
    task automatic applyStimulus(input bit is_sts, input int n, input logic [15:0] first,
                                 input bit seq, input int plan, input int at, input int maxgap);
        exp_t e;
        src_t s;
        logic [15:0] w;
        src_t tmp[$];
        e.words = '0;
        for (int i = 0; i < n; i++) begin
            w = seq ? 16'(first + 16'(i)) : 16'($urandom);
            s.word = w;
            s.gap = (maxgap > 0) ? 4'($urandom_range(0, maxgap)) : 4'd0;
            tmp.push_back(s);
            e.words[i*16 +: 16] = w;
        end
        e.plan = 2'(plan);
        e.at = 4'(at);
        exp_q.push_back(e);
        planned++;
        if (plan != PLAN_RESET) last_owner_sts = is_sts;
        foreach (tmp[i]) begin
            if (is_sts) sts_src.push_back(tmp[i]);
            else trc_src.push_back(tmp[i]);
        end
    endtask

    // Both requesters loaded at once; frame order follows the fairness rule.
    task automatic applyContention(input int n_each);
        logic [15:0] tw[$];
        logic [15:0] sw[$];
        src_t s;
        exp_t e;
        int tpos, spos;
        bit use_sts;
        for (int i = 0; i < n_each; i++) begin
            tw.push_back(16'($urandom));
            sw.push_back(16'($urandom));
        end
        tpos = 0;
        spos = 0;
        while (tpos < n_each || spos < n_each) begin
            use_sts = (spos < n_each) && (!last_owner_sts || tpos >= n_each);
            e.words = '0;
            for (int i = 0; i < WPF; i++) begin
                if (use_sts) e.words[i*16 +: 16] = sw[spos + i];
                else e.words[i*16 +: 16] = tw[tpos + i];
            end
            if (use_sts) spos += WPF;
            else tpos += WPF;
            e.plan = 2'(PLAN_NORMAL);
            e.at = 4'd0;
            exp_q.push_back(e);
            planned++;
            last_owner_sts = use_sts;
        end
        for (int i = 0; i < n_each; i++) begin
            s.gap = 4'd0;
            s.word = tw[i];
            trc_src.push_back(s);
            s.word = sw[i];
            sts_src.push_back(s);
        end
    endtask

    task automatic waitFrames();
        int cyc = 0;
        while (frames_done < planned && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (frames_done < planned) checkOutput("frame_timeout", 32'(frames_done), 32'(planned));
    endtask

    // Sink-side pulse on the dClk inputs, then time for the synchroniser and update.
    task automatic pulse(input bit f, input bit a);
        @(posedge clk);
        #1;
        tx_free = f;
        rxFrameReset = a;
        @(posedge clk);
        #1;
        tx_free = 1'b0;
        rxFrameReset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Trace requester driver: presents queued words, honouring pre-word gaps.
    initial begin : trc_drv
        bit hs;
        int gcnt;
        trc_valid = 1'b0;
        trc_word = 16'h0;
        gcnt = 0;
        forever begin
            @(negedge clk);
            hs = trc_valid && trc_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(trc_src.pop_front());
                gcnt = 0;
            end
            if (trc_src.size() > 0 && gcnt >= int'(trc_src[0].gap)) begin
                trc_valid = 1'b1;
                trc_word = trc_src[0].word;
            end else begin
                trc_valid = 1'b0;
                if (trc_src.size() > 0) gcnt++;
            end
        end
    end

    // Status requester driver, same protocol as the trace driver.
    initial begin : sts_drv
        bit hs;
        int gcnt;
        sts_valid = 1'b0;
        sts_word = 16'h0;
        gcnt = 0;
        forever begin
            @(negedge clk);
            hs = sts_valid && sts_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                void'(sts_src.pop_front());
                gcnt = 0;
            end
            if (sts_src.size() > 0 && gcnt >= int'(sts_src[0].gap)) begin
                sts_valid = 1'b1;
                sts_word = sts_src[0].word;
            end else begin
                sts_valid = 1'b0;
                if (sts_src.size() > 0) gcnt++;
            end
        end
    end

    // Tracks any cycle where both requesters are granted at once.
    always @(negedge clk) begin
        if (trc_ready && sts_ready) both_ready_cycles++;
    end

    // Sink and monitor: consumes frames word by word and compares with the scoreboard.
    initial begin : sink
        exp_t item;
        int idx, cyc;
        bit aborted, done;
        tx_free = 1'b0;
        rxFrameReset = 1'b0;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            item = exp_q.pop_front();
            cyc = 0;
            @(negedge clk);
            while (!transmitIn && cyc < 4000) begin
                @(negedge clk);
                cyc++;
            end
            if (!transmitIn) begin
                checkOutput("arm_timeout", 32'(transmitIn), 32'd1);
                frames_done++;
                continue;
            end
            idx = 0;
            aborted = 1'b0;
            done = 1'b0;
            while (!done) begin
                checkOutput("tx_word", 32'(tx_word), 32'(item.words[idx*16 +: 16]));
                checkOutput("transmitIn_high", 32'(transmitIn), 32'd1);
                if (item.plan == 2'(PLAN_RESET) && idx == int'(item.at)) begin
                    halted = 1'b1;
                    cyc = 0;
                    while (transmitIn && cyc < 500) begin
                        @(negedge clk);
                        cyc++;
                    end
                    exp_frames = 0;
                    halted = 1'b0;
                    done = 1'b1;
                end else if (item.plan == 2'(PLAN_BOTH) && !aborted && idx == int'(item.at)) begin
                    pulse(1'b1, 1'b1);
                    idx = 0;
                    aborted = 1'b1;
                end else begin
                    pulse(1'b1, 1'b0);
                    if (idx == WPF - 1) begin
                        exp_frames++;
                        checkOutput("transmitIn_low", 32'(transmitIn), 32'd0);
                        checkOutput("tx_word_idle", 32'(tx_word), 32'd0);
                        checkOutput("frames_sent", 32'(frames_sent), 32'(exp_frames));
                        done = 1'b1;
                    end else begin
                        idx++;
                        if (item.plan == 2'(PLAN_ABORT) && !aborted && idx == int'(item.at)) begin
                            pulse(1'b0, 1'b1);
                            idx = 0;
                            aborted = 1'b1;
                        end
                    end
                end
            end
            frames_done++;
        end
    end

    // Sequencer: reset, directed scenarios, contention, then randomized frames.
    initial begin : main
        int cyc, n, plan, at;
        bit is_sts;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_transmitIn", 32'(transmitIn), 32'd0);
        checkOutput("rst_tx_word", 32'(tx_word), 32'd0);
        checkOutput("rst_frames_sent", 32'(frames_sent), 32'd0);
        checkOutput("rst_trc_ready", 32'(trc_ready), 32'd0);
        checkOutput("rst_sts_ready", 32'(sts_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset during SEND");
        applyStimulus(1'b0, WPF, 16'h0, 1'b0, PLAN_RESET, 2, 0);
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("halt_reached", 32'(halted), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midsend_rst_transmitIn", 32'(transmitIn), 32'd0);
        checkOutput("midsend_rst_frames_sent", 32'(frames_sent), 32'd0);
        last_owner_sts = 1'b0;
        waitFrames();

        $display("[TB] continuous trace frame and latency");
        applyStimulus(1'b0, WPF, 16'h1000, 1'b1, PLAN_NORMAL, 0, 0);
        cyc = 0;
        @(negedge clk);
        while (!(trc_valid && trc_ready) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!transmitIn && n < 100);
        checkOutput("latency", 32'(n), 32'(WPF + 1));
        waitFrames();

        $display("[TB] abort after fourth free");
        applyStimulus(1'b0, WPF, 16'h2000, 1'b1, PLAN_ABORT, 4, 0);
        waitFrames();

        $display("[TB] free and abort together");
        applyStimulus(1'b0, WPF, 16'h3000, 1'b1, PLAN_BOTH, 2, 0);
        waitFrames();

        $display("[TB] three words then pad");
        applyStimulus(1'b0, 3, 16'h4000, 1'b1, PLAN_NORMAL, 0, 0);
        waitFrames();

        $display("[TB] contention between requesters");
        applyContention(2 * WPF);
        waitFrames();

        $display("[TB] randomized frames");
        for (int f = 0; f < 14; f++) begin
            is_sts = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, WPF - 1) : WPF;
            plan = $urandom_range(0, 2);
            at = (plan == PLAN_ABORT) ? $urandom_range(1, WPF - 1)
               : (plan == PLAN_BOTH) ? $urandom_range(0, WPF - 1) : 0;
            applyStimulus(is_sts, n, 16'h0, 1'b0, plan, at, 3);
            waitFrames();
        end

        checkOutput("ready_exclusive", 32'(both_ready_cycles), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a scenario wedges beyond every bounded wait.
    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
